dcache_data_write_responder: RTL and testbench
==============================================

Name: dcache_data_write_responder

Overview:
- Sink end of the data-array write-request arbiter. It accepts one arbitrated write request per cycle, tagged with the winning requester index (0-7).
- It buffers the request, drives the registered single-write-port data SRAM interface, and returns a one-hot write-completion acknowledge to the originating requester after the array write latency.
- It sits between the write arbiter and the data array, so that requesters can retire their write state only after the write has committed.

Parameters:
- QUEUE_DEPTH, 2, request buffer entries (power of two, >=2).
- WRITE_LATENCY, 2, cycles from io_sram_wen asserted to write committed (>=1).
- N_SRC, 8, number of requesters; width of io_ack; io_in_bits_src width = log2(N_SRC).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- io_in_valid  in  1  request valid.
- io_in_ready  out  1  request accepted when valid&ready.
- io_in_bits_src  in  3  requester index of the arbitration winner.
- io_in_bits_way_en  in  8  way select, expected one-hot.
- io_in_bits_addr  in  12  array row/bank address.
- io_in_bits_data  in  128  write data.
- io_sram_busy  in  1  array port taken by a higher-priority read this cycle; no issue.
- io_sram_wen  out  1  registered write strobe.
- io_sram_way_en  out  8  registered way select.
- io_sram_addr  out  12  registered address.
- io_sram_wdata  out  128  registered data.
- io_ack  out  8  one-hot completion pulse, indexed by src.
- io_err  out  1  sticky: a request with way_en having more than one bit set was seen.
- io_idle  out  1  buffer empty, no write issued this cycle, ack pipe empty.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Buffer pointers and count cleared; ack pipeline cleared.
  - io_sram_wen=0; io_sram_way_en/addr/wdata=0; io_ack=0; io_err=0.
  - io_in_ready=0 while reset is low.
  - Reset asserted mid-operation discards buffered and in-flight requests; none of them is acked.
- Enqueue:
  - io_in_ready = !full (count < QUEUE_DEPTH). It does not depend on io_sram_busy or on a same-cycle dequeue, so a full buffer does not accept even when the head drains in that cycle.
  - There is no fall-through: an entry enqueued at edge T is issuable in cycle T+1 at the earliest.
- Issue:
  - Each cycle, if the buffer is non-empty and io_sram_busy==0, the head is dequeued.
  - At the next edge the io_sram_* registers load the head fields, and io_sram_wen=1 for exactly one cycle per dequeued entry.
  - If no dequeue happens, io_sram_wen=0 and the other io_sram_* outputs hold their last values.
  - Sustained throughput: 1 write/cycle while busy==0 and valid is held.
- Zero way_en:
  - The request is accepted and dequeued normally, but io_sram_wen stays 0 for it.
  - It is still acked with normal timing.
- Multi-hot way_en:
  - The write is issued as given.
  - io_err is set the cycle after enqueue and stays at 1 until reset.
- Ack:
  - The ack pipeline is a shift register of WRITE_LATENCY stages, each holding {valid, src}.
  - A dequeue at edge D loads stage 0 at that same edge.
  - io_ack[src] is 1 for exactly one cycle, starting at edge D+WRITE_LATENCY, i.e. WRITE_LATENCY cycles after the io_sram_wen cycle.
  - At most one io_ack bit is set per cycle. Acks arrive in issue order, which is also acceptance order.
- Latency: accept at edge T, io_sram_wen high from edge T+1 (busy==0), io_ack high from edge T+1+WRITE_LATENCY.
- Simultaneous enqueue and dequeue on a non-full buffer: the count is unchanged and both operations take effect.
- Pointers wrap modulo QUEUE_DEPTH.
- io_idle = (count==0) & !io_sram_wen & (no valid ack stage); it is 1 after reset.

Test Plan:
- Single write: src=5, way_en=0x04, addr=0x3A1, data=0xDEAD..BEEF accepted at edge T -> wen=1 with these fields at T+1; io_ack=0x20 for one cycle at T+3; io_idle=1 at T+4.
- Back-to-back: srcs 0,1,2,3 on four consecutive edges with busy=0 -> wen high for 4 consecutive cycles; io_ack=0x01,0x02,0x04,0x08 in consecutive cycles; io_in_ready stays 1 throughout.
- Backpressure: busy=1 held, 3 requests offered -> 2 accepted, then ready=0, wen=0. Release busy -> the 2 writes issue in order, ready returns to 1 the cycle after the first dequeue, and the third request is then accepted.
- Zero way_en: src=7, way_en=0x00 -> no wen pulse; io_ack=0x80 at T+3; io_err stays 0.
- Multi-hot: way_en=0x03, src=2 -> write issued with way_en=0x03; io_err=1 from T+1 and still 1 100 cycles later; ack=0x04 at T+3.
- Reset mid-flight: 2 entries buffered and 1 ack in the pipe, reset=0 for one edge -> wen=0, io_ack=0, io_err=0, io_idle=1 after the edge; no ack for the discarded entries ever appears.

Source files
------------

// File: rtl/dcache_data_write_responder_if.sv
// Request/SRAM/ack bundle between the write arbiter, the responder and the data array.
interface dcache_data_write_responder_if #(
  parameter int unsigned N_SRC = 8
);
  localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned WAY_W  = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 128;

  logic              io_in_valid;
  logic              io_in_ready;
  logic [SRC_W-1:0]  io_in_bits_src;
  logic [WAY_W-1:0]  io_in_bits_way_en;
  logic [ADDR_W-1:0] io_in_bits_addr;
  logic [DATA_W-1:0] io_in_bits_data;
  logic              io_sram_busy;
  logic              io_sram_wen;
  logic [WAY_W-1:0]  io_sram_way_en;
  logic [ADDR_W-1:0] io_sram_addr;
  logic [DATA_W-1:0] io_sram_wdata;
  logic [N_SRC-1:0]  io_ack;
  logic              io_err;
  logic              io_idle;

  modport master (
    output io_in_valid, io_in_bits_src, io_in_bits_way_en, io_in_bits_addr,
           io_in_bits_data, io_sram_busy,
    input  io_in_ready, io_sram_wen, io_sram_way_en, io_sram_addr, io_sram_wdata,
           io_ack, io_err, io_idle
  );

  modport slave (
    input  io_in_valid, io_in_bits_src, io_in_bits_way_en, io_in_bits_addr,
           io_in_bits_data, io_sram_busy,
    output io_in_ready, io_sram_wen, io_sram_way_en, io_sram_addr, io_sram_wdata,
           io_ack, io_err, io_idle
  );
endinterface

// File: rtl/dcache_data_write_responder.sv
// Buffers arbitrated data-array writes, drives the registered SRAM write port and
// returns a one-hot completion ack to the requester once the write has committed.
module dcache_data_write_responder #(
  parameter int unsigned QUEUE_DEPTH   = 2,
  parameter int unsigned WRITE_LATENCY = 2,
  parameter int unsigned N_SRC         = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  dcache_data_write_responder_if.slave io
);
  localparam int unsigned SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned WAY_W  = 8;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 128;

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [WAY_W-1:0]  way_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic             valid;
    logic [SRC_W-1:0] src;
  } ack_stage_t;

  req_t                             mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]                 count_q, count_d;
  ack_stage_t [WRITE_LATENCY-1:0]   pipe_q, pipe_d;
  logic                             wen_q, wen_d;
  logic [WAY_W-1:0]                 way_q, way_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic [N_SRC-1:0]                 ack_q, ack_d;
  logic                             err_q, err_d;
  logic                             idle_q, idle_d;

  req_t in_req;
  req_t head;
  logic full;
  logic enq;
  logic deq;
  logic multi_hot;
  logic pipe_busy;

  assign in_req    = {io.io_in_bits_src, io.io_in_bits_way_en, io.io_in_bits_addr,
                      io.io_in_bits_data};
  assign full      = (count_q == CNT_W'(QUEUE_DEPTH));
  assign io.io_in_ready = reset & ~full;
  assign enq       = io.io_in_valid & io.io_in_ready;
  assign deq       = (count_q != '0) & ~io.io_sram_busy;
  assign head      = mem_q[rd_ptr_q];
  assign multi_hot = (in_req.way_en & (in_req.way_en - WAY_W'(1))) != '0;

  // Next-state: queue bookkeeping, SRAM port load, ack shift pipe, status flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wen_d    = 1'b0;
    way_d    = way_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = '0;
    err_d    = err_q | (enq & multi_hot);
    pipe_d   = pipe_q;
    pipe_busy = 1'b0;

    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wen_d    = |head.way_en;
      way_d    = head.way_en;
      addr_d   = head.addr;
      wdata_d  = head.data;
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    pipe_d[0] = '{valid: deq, src: head.src};
    for (int i = 1; i < int'(WRITE_LATENCY); i++) pipe_d[i] = pipe_q[i-1];
    for (int i = 0; i < int'(WRITE_LATENCY); i++) pipe_busy = pipe_busy | pipe_d[i].valid;

    // Last stage turns into the one-hot completion pulse.
    ack_d[pipe_q[WRITE_LATENCY-1].src] = pipe_q[WRITE_LATENCY-1].valid;

    idle_d = (count_d == '0) & ~wen_d & ~pipe_busy;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pipe_q   <= '0;
      wen_q    <= 1'b0;
      way_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pipe_q   <= pipe_d;
      wen_q    <= wen_d;
      way_q    <= way_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      idle_q   <= idle_d;
    end
  end

  // Payload storage needs no reset; pointers alone define validity.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= in_req;
  end

  assign io.io_sram_wen    = wen_q;
  assign io.io_sram_way_en = way_q;
  assign io.io_sram_addr   = addr_q;
  assign io.io_sram_wdata  = wdata_q;
  assign io.io_ack         = ack_q;
  assign io.io_err         = err_q;
  assign io.io_idle        = idle_q;
endmodule

// File: tb/tb_dcache_data_write_responder.sv
// Directed vector table plus hand sequences for backpressure and mid-flight reset.
module tb_dcache_data_write_responder;
  logic clock;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  localparam logic [127:0] D0 = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] D1 = 128'h1111_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] D2 = 128'h2222_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [127:0] D3 = 128'h3333_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [127:0] D4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [127:0] D5 = 128'h5555_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [127:0] D6 = 128'h6666_0000_0000_0000_0000_0000_0000_0006;
  localparam logic [127:0] D7 = 128'h7777_0000_0000_0000_0000_0000_0000_0007;
  localparam logic [127:0] D8 = 128'h8888_0000_0000_0000_0000_0000_0000_0008;
  localparam logic [127:0] D9 = 128'h9999_0000_0000_0000_0000_0000_0000_0009;

  dcache_data_write_responder_if #(.N_SRC(8)) io_if ();

  dcache_data_write_responder #(
    .QUEUE_DEPTH(2), .WRITE_LATENCY(2), .N_SRC(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (io_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         valid;
    logic [2:0]   src;
    logic [7:0]   way;
    logic [11:0]  addr;
    logic [127:0] data;
    logic         exp_wen;
    logic [7:0]   exp_way;
    logic [11:0]  exp_addr;
    logic [127:0] exp_data;
    logic [7:0]   exp_ack;
    logic         exp_err;
    logic         exp_idle;
    logic         chk_idle;
  } vec_t;

  vec_t vecs [23];

  function automatic vec_t mk(logic v, logic [2:0] s, logic [7:0] w, logic [11:0] a,
                              logic [127:0] d, logic ew, logic [7:0] eway,
                              logic [11:0] eaddr, logic [127:0] ed, logic [7:0] eack,
                              logic eerr, logic eidle, logic ci);
    vec_t r;
    r.valid = v; r.src = s; r.way = w; r.addr = a; r.data = d;
    r.exp_wen = ew; r.exp_way = eway; r.exp_addr = eaddr; r.exp_data = ed;
    r.exp_ack = eack; r.exp_err = eerr; r.exp_idle = eidle; r.chk_idle = ci;
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] w,
                       input logic [11:0] a, input logic [127:0] d);
    io_if.io_in_valid       = v;
    io_if.io_in_bits_src    = s;
    io_if.io_in_bits_way_en = w;
    io_if.io_in_bits_addr   = a;
    io_if.io_in_bits_data   = d;
  endtask

  logic seen;

  initial begin
    reset = 1'b0;
    io_if.io_sram_busy = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 12'h000, '0);
    step();
    step();
    chk("rst_ready", 128'(io_if.io_in_ready), 128'(0));
    chk("rst_wen",   128'(io_if.io_sram_wen), 128'(0));
    chk("rst_way",   128'(io_if.io_sram_way_en), 128'(0));
    chk("rst_addr",  128'(io_if.io_sram_addr), 128'(0));
    chk("rst_wdata", io_if.io_sram_wdata, 128'(0));
    chk("rst_ack",   128'(io_if.io_ack), 128'(0));
    chk("rst_err",   128'(io_if.io_err), 128'(0));
    chk("rst_idle",  128'(io_if.io_idle), 128'(1));
    reset = 1'b1;
    step();

    //              v  src   way    addr     data  wen way   addr     edata ack  err idle chk
    vecs[0]  = mk(1, 3'd5, 8'h04, 12'h3A1, D0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[1]  = mk(0, 3'd0, 8'h00, 12'h000, '0, 1, 8'h04, 12'h3A1, D0, 8'h00, 0, 0, 1);
    vecs[2]  = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[3]  = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h20, 0, 0, 0);
    vecs[4]  = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 1, 1);
    vecs[5]  = mk(1, 3'd0, 8'h01, 12'h010, D1, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[6]  = mk(1, 3'd1, 8'h02, 12'h011, D2, 1, 8'h01, 12'h010, D1, 8'h00, 0, 0, 1);
    vecs[7]  = mk(1, 3'd2, 8'h04, 12'h012, D3, 1, 8'h02, 12'h011, D2, 8'h00, 0, 0, 1);
    vecs[8]  = mk(1, 3'd3, 8'h08, 12'h013, D4, 1, 8'h04, 12'h012, D3, 8'h01, 0, 0, 1);
    vecs[9]  = mk(0, 3'd0, 8'h00, 12'h000, '0, 1, 8'h08, 12'h013, D4, 8'h02, 0, 0, 1);
    vecs[10] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h04, 0, 0, 1);
    vecs[11] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h08, 0, 0, 0);
    vecs[12] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 1, 1);
    vecs[13] = mk(1, 3'd7, 8'h00, 12'h100, D5, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[14] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[15] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 0, 1);
    vecs[16] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h80, 0, 0, 0);
    vecs[17] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 0, 1, 1);
    vecs[18] = mk(1, 3'd2, 8'h03, 12'h200, D6, 0, 8'h00, 12'h000, '0, 8'h00, 1, 0, 1);
    vecs[19] = mk(0, 3'd0, 8'h00, 12'h000, '0, 1, 8'h03, 12'h200, D6, 8'h00, 1, 0, 1);
    vecs[20] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 1, 0, 1);
    vecs[21] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h04, 1, 0, 0);
    vecs[22] = mk(0, 3'd0, 8'h00, 12'h000, '0, 0, 8'h00, 12'h000, '0, 8'h00, 1, 1, 1);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].valid, vecs[i].src, vecs[i].way, vecs[i].addr, vecs[i].data);
      chk($sformatf("v%0d_ready", i), 128'(io_if.io_in_ready), 128'(1));
      step();
      chk($sformatf("v%0d_wen", i), 128'(io_if.io_sram_wen), 128'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        chk($sformatf("v%0d_way", i),  128'(io_if.io_sram_way_en), 128'(vecs[i].exp_way));
        chk($sformatf("v%0d_addr", i), 128'(io_if.io_sram_addr), 128'(vecs[i].exp_addr));
        chk($sformatf("v%0d_data", i), io_if.io_sram_wdata, vecs[i].exp_data);
      end
      chk($sformatf("v%0d_ack", i), 128'(io_if.io_ack), 128'(vecs[i].exp_ack));
      chk($sformatf("v%0d_err", i), 128'(io_if.io_err), 128'(vecs[i].exp_err));
      if (vecs[i].chk_idle)
        chk($sformatf("v%0d_idle", i), 128'(io_if.io_idle), 128'(vecs[i].exp_idle));
    end

    drive(1'b0, 3'd0, 8'h00, 12'h000, '0);
    repeat (100) step();
    chk("err_sticky", 128'(io_if.io_err), 128'(1));

    // Backpressure: buffer fills behind a busy port, then drains in order.
    io_if.io_sram_busy = 1'b1;
    drive(1'b1, 3'd1, 8'h10, 12'h301, D7);
    chk("bp_ready_a", 128'(io_if.io_in_ready), 128'(1));
    step();
    drive(1'b1, 3'd4, 8'h20, 12'h302, D8);
    chk("bp_ready_b", 128'(io_if.io_in_ready), 128'(1));
    step();
    chk("bp_wen_b", 128'(io_if.io_sram_wen), 128'(0));
    drive(1'b1, 3'd6, 8'h40, 12'h303, D9);
    chk("bp_ready_full", 128'(io_if.io_in_ready), 128'(0));
    step();
    chk("bp_wen_full", 128'(io_if.io_sram_wen), 128'(0));
    chk("bp_ready_hold", 128'(io_if.io_in_ready), 128'(0));
    io_if.io_sram_busy = 1'b0;
    chk("bp_ready_release", 128'(io_if.io_in_ready), 128'(0));
    step();
    chk("bp_wen_a", 128'(io_if.io_sram_wen), 128'(1));
    chk("bp_addr_a", 128'(io_if.io_sram_addr), 128'(12'h301));
    chk("bp_ready_back", 128'(io_if.io_in_ready), 128'(1));
    step();
    drive(1'b0, 3'd0, 8'h00, 12'h000, '0);
    chk("bp_wen_b2", 128'(io_if.io_sram_wen), 128'(1));
    chk("bp_addr_b", 128'(io_if.io_sram_addr), 128'(12'h302));
    chk("bp_way_b", 128'(io_if.io_sram_way_en), 128'(8'h20));
    step();
    chk("bp_wen_c", 128'(io_if.io_sram_wen), 128'(1));
    chk("bp_addr_c", 128'(io_if.io_sram_addr), 128'(12'h303));
    chk("bp_data_c", io_if.io_sram_wdata, D9);
    chk("bp_ack_a", 128'(io_if.io_ack), 128'(8'h02));
    step();
    chk("bp_wen_done", 128'(io_if.io_sram_wen), 128'(0));
    chk("bp_ack_b", 128'(io_if.io_ack), 128'(8'h10));
    step();
    chk("bp_ack_c", 128'(io_if.io_ack), 128'(8'h40));
    step();
    chk("bp_ack_end", 128'(io_if.io_ack), 128'(0));
    chk("bp_idle", 128'(io_if.io_idle), 128'(1));

    // Mid-flight reset: two entries buffered, one ack in the pipe.
    drive(1'b1, 3'd0, 8'h01, 12'h400, D1);
    step();
    drive(1'b1, 3'd3, 8'h02, 12'h401, D2);
    step();
    chk("mr_wen_x", 128'(io_if.io_sram_wen), 128'(1));
    drive(1'b1, 3'd5, 8'h04, 12'h402, D3);
    io_if.io_sram_busy = 1'b1;
    step();
    drive(1'b0, 3'd0, 8'h00, 12'h000, '0);
    reset = 1'b0;
    chk("mr_ready_in_rst", 128'(io_if.io_in_ready), 128'(0));
    step();
    chk("mr_wen", 128'(io_if.io_sram_wen), 128'(0));
    chk("mr_ack", 128'(io_if.io_ack), 128'(0));
    chk("mr_err", 128'(io_if.io_err), 128'(0));
    chk("mr_idle", 128'(io_if.io_idle), 128'(1));
    reset = 1'b1;
    io_if.io_sram_busy = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step();
      if (io_if.io_ack != '0 || io_if.io_sram_wen) seen = 1'b1;
    end
    chk("mr_no_stale_ack", 128'(seen), 128'(0));
    chk("mr_idle_after", 128'(io_if.io_idle), 128'(1));
    chk("mr_ready_after", 128'(io_if.io_in_ready), 128'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
